sparse_mult_sched: RTL and testbench

Sequencer for the sparse polynomial multiplier datapath on the CW305 target. For each multiplication it walks the sparse operand's position list (real terms), interleaves a programmed number of dummy terms, and picks the order from an external random bit. Real and dummy terms take identical cycle counts and memory-access patterns. It sits between the host command/load logic and the poly_mult accumulate datapath. Sparse positions come from a position RAM; each selected term goes to the datapath through a valid/ready handshake.

---
 rtl/sparse_mult_sched_if.sv | 31 +++
 rtl/sparse_mult_sched.sv | 114 +++++++++++
 tb/tb_sparse_mult_sched.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/sparse_mult_sched_if.sv
// Handshake and bus bundle between the sparse-term sequencer, the host/load logic,
// the position RAM and the poly_mult datapath.
interface sparse_mult_sched_if #(
  parameter int LOG_WEIGHT = 7,
  parameter int POS_W      = 16
);
  logic                  start_i;
  logic [LOG_WEIGHT-1:0] weight_i;
  logic [LOG_WEIGHT-1:0] dummy_i;
  logic                  rnd_i;
  logic [POS_W-1:0]      dpos_i;
  logic                  pos_rd_o;
  logic [LOG_WEIGHT-1:0] pos_addr_o;
  logic [POS_W-1:0]      pos_rdata_i;
  logic                  op_valid_o;
  logic                  op_ready_i;
  logic [POS_W-1:0]      op_pos_o;
  logic                  op_dummy_o;
  logic                  busy_o;
  logic                  done_o;

  modport slave (
    input  start_i, weight_i, dummy_i, rnd_i, dpos_i, pos_rdata_i, op_ready_i,
    output pos_rd_o, pos_addr_o, op_valid_o, op_pos_o, op_dummy_o, busy_o, done_o
  );

  modport master (
    output start_i, weight_i, dummy_i, rnd_i, dpos_i, pos_rdata_i, op_ready_i,
    input  pos_rd_o, pos_addr_o, op_valid_o, op_pos_o, op_dummy_o, busy_o, done_o
  );
endinterface

// File: rtl/sparse_mult_sched.sv
// Sparse multiplier sequencer: interleaves real and dummy terms in a random order,
// giving both kinds the same 4-cycle schedule and the same position-RAM read pattern.
module sparse_mult_sched #(
  parameter int LOG_WEIGHT = 7,
  parameter int POS_W      = 16
) (
  input logic               clk,
  input logic               rst_i,
  sparse_mult_sched_if.slave bus
);

  typedef enum logic [2:0] {IDLE, DECIDE, FETCH, LOAD, ISSUE, DONE} state_t;

  state_t                state, state_nxt;
  logic [LOG_WEIGHT-1:0] real_left, real_left_nxt;
  logic [LOG_WEIGHT-1:0] dummy_left, dummy_left_nxt;
  logic [LOG_WEIGHT-1:0] real_idx, real_idx_nxt;
  logic                  is_dummy, is_dummy_nxt;
  logic [POS_W-1:0]      op_pos, op_pos_nxt;
  logic                  op_dummy, op_dummy_nxt;

  logic                  pos_rd, op_valid, busy, done;
  logic [LOG_WEIGHT-1:0] pos_addr;

  // NOTE: every variable gets its hold value first, so no path through the case
  // can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt      = state;
    real_left_nxt  = real_left;
    dummy_left_nxt = dummy_left;
    real_idx_nxt   = real_idx;
    is_dummy_nxt   = is_dummy;
    op_pos_nxt     = op_pos;
    op_dummy_nxt   = op_dummy;

    case (state)
      IDLE: begin
        if (bus.start_i) begin
          real_left_nxt  = bus.weight_i;
          dummy_left_nxt = bus.dummy_i;
          real_idx_nxt   = '0;
          state_nxt      = (bus.weight_i == '0 && bus.dummy_i == '0) ? DONE : DECIDE;
        end
      end
      DECIDE: begin
        // An exhausted pool forces the other kind, so neither counter can underflow.
        if (real_left == '0)       is_dummy_nxt = 1'b1;
        else if (dummy_left == '0) is_dummy_nxt = 1'b0;
        else                       is_dummy_nxt = bus.rnd_i;
        state_nxt = FETCH;
      end
      FETCH: state_nxt = LOAD;
      LOAD: begin
        op_pos_nxt   = is_dummy ? bus.dpos_i : bus.pos_rdata_i;
        op_dummy_nxt = is_dummy;
        state_nxt    = ISSUE;
      end
      ISSUE: begin
        if (bus.op_ready_i) begin
          if (op_dummy) begin
            dummy_left_nxt = dummy_left - LOG_WEIGHT'(1);
          end else begin
            real_left_nxt = real_left - LOG_WEIGHT'(1);
            real_idx_nxt  = real_idx + LOG_WEIGHT'(1);
          end
          state_nxt = (real_left_nxt == '0 && dummy_left_nxt == '0) ? DONE : DECIDE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state      <= IDLE;
      real_left  <= '0;
      dummy_left <= '0;
      real_idx   <= '0;
      is_dummy   <= 1'b0;
      op_pos     <= '0;
      op_dummy   <= 1'b0;
      pos_rd     <= 1'b0;
      pos_addr   <= '0;
      op_valid   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      real_left  <= real_left_nxt;
      dummy_left <= dummy_left_nxt;
      real_idx   <= real_idx_nxt;
      is_dummy   <= is_dummy_nxt;
      op_pos     <= op_pos_nxt;
      op_dummy   <= op_dummy_nxt;
      // Outputs are flopped from the next state so none is a decode of live inputs.
      pos_rd     <= (state_nxt == FETCH);
      pos_addr   <= (state_nxt == FETCH) ? real_idx_nxt : '0;
      op_valid   <= (state_nxt == ISSUE);
      busy       <= (state_nxt != IDLE);
      done       <= (state_nxt == DONE);
    end
  end

  assign bus.pos_rd_o   = pos_rd;
  assign bus.pos_addr_o = pos_addr;
  assign bus.op_valid_o = op_valid;
  assign bus.op_pos_o   = op_pos;
  assign bus.op_dummy_o = op_dummy;
  assign bus.busy_o     = busy;
  assign bus.done_o     = done;

endmodule

// File: tb/tb_sparse_mult_sched.sv
// Self-checking bench for sparse_mult_sched: directed and randomized jobs compared
// against a term-list model built from the weight/dummy counts and random decisions.
module tb_sparse_mult_sched;
  localparam int LW = 7;
  localparam int PW = 16;

  typedef struct packed {
    logic [PW-1:0] pos;
    logic          dummy;
  } term_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sparse_mult_sched_if #(.LOG_WEIGHT(LW), .POS_W(PW)) bus ();
  sparse_mult_sched #(.LOG_WEIGHT(LW), .POS_W(PW)) dut (.clk(clk), .rst_i(rst), .bus(bus));

  logic [PW-1:0] ram      [1<<LW];
  bit            rnd_seq  [256];
  logic [PW-1:0] dpos_seq [256];
  term_t         exp_q[$];
  term_t         obs_q[$];
  int            n_checks = 0;
  int            n_err    = 0;
  int            rd_cnt, stall_cnt, lat;

  // Position RAM: data valid the cycle after the strobe, garbage otherwise.
  always @(posedge clk) begin
    if (rst)                 bus.pos_rdata_i <= '0;
    else if (bus.pos_rd_o)   bus.pos_rdata_i <= ram[bus.pos_addr_o];
    else                     bus.pos_rdata_i <= PW'($urandom);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected term order: each slot is dummy if no reals remain, real if no dummies
  // remain, otherwise the random bit decides. Reals read RAM in ascending order.
  function automatic void build_expected(input int w, input int d);
    int r = w, dm = d, idx = 0, k = 0;
    term_t t;
    exp_q.delete();
    while (r + dm > 0) begin
      t.dummy = (r == 0) ? 1'b1 : (dm == 0) ? 1'b0 : rnd_seq[k];
      t.pos   = t.dummy ? dpos_seq[k] : ram[idx];
      if (t.dummy) dm--;
      else begin r--; idx++; end
      exp_q.push_back(t);
      k++;
    end
  endfunction

  task automatic randomize_data();
    for (int i = 0; i < (1<<LW); i++) ram[i] = PW'($urandom);
    for (int i = 0; i < 256; i++) begin
      rnd_seq[i]  = 1'($urandom);
      dpos_seq[i] = PW'($urandom);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pos_rd"},   bus.pos_rd_o,   0);
    check({tag, "_pos_addr"}, bus.pos_addr_o, 0);
    check({tag, "_valid"},    bus.op_valid_o, 0);
    check({tag, "_pos"},      bus.op_pos_o,   0);
    check({tag, "_dummy"},    bus.op_dummy_o, 0);
    check({tag, "_busy"},     bus.busy_o,     0);
    check({tag, "_done"},     bus.done_o,     0);
  endtask

  // Runs one job. Cycle 1 is the cycle in which start_i is high in IDLE.
  task automatic run_job(input string tag, input int w, input int d, input int stall_pct,
                         input int first_stall, input bit poke_start);
    int    cyc, k, reals, stalls_left;
    bit    hold_valid, ready;
    term_t held, t;
    obs_q.delete();
    rd_cnt = 0; stall_cnt = 0; lat = -1;
    build_expected(w, d);
    @(negedge clk);
    bus.start_i = 1'b1; bus.weight_i = LW'(w); bus.dummy_i = LW'(d);
    bus.rnd_i = rnd_seq[0]; bus.dpos_i = dpos_seq[0]; bus.op_ready_i = 1'b1;
    cyc = 1; k = 0; reals = 0; stalls_left = first_stall; hold_valid = 1'b0;
    while (lat < 0 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      bus.start_i = 1'b0;
      if (poke_start && cyc == 6) begin
        bus.start_i = 1'b1; bus.weight_i = LW'(5); bus.dummy_i = LW'(9);
      end
      check({tag, "_busy"}, bus.busy_o, 1);
      if (bus.pos_rd_o) begin
        rd_cnt++;
        check({tag, "_pos_addr"}, bus.pos_addr_o, reals);
      end
      if (hold_valid) begin
        check({tag, "_hold_valid"}, bus.op_valid_o, 1);
        check({tag, "_hold_pos"},   bus.op_pos_o,   held.pos);
        check({tag, "_hold_dummy"}, bus.op_dummy_o, held.dummy);
      end
      hold_valid = 1'b0;
      if (bus.op_valid_o) begin
        if (k == 0 && stalls_left > 0) begin
          ready = 1'b0;
          stalls_left--;
        end else begin
          ready = ($urandom_range(99) >= stall_pct);
        end
        bus.op_ready_i = ready;
        t.pos = bus.op_pos_o; t.dummy = bus.op_dummy_o;
        if (ready) begin
          obs_q.push_back(t);
          if (!t.dummy) reals++;
          k++;
          bus.rnd_i  = rnd_seq[k];
          bus.dpos_i = dpos_seq[k];
        end else begin
          stall_cnt++;
          hold_valid = 1'b1;
          held = t;
        end
      end else begin
        bus.op_ready_i = 1'($urandom);
      end
      if (bus.done_o) lat = cyc;
    end
    check({tag, "_latency"}, lat, 2 + 4 * (w + d) + stall_cnt);
    check({tag, "_rd_count"}, rd_cnt, w + d);
    check({tag, "_term_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s_term%0d_pos", tag, i),   obs_q[i].pos,   exp_q[i].pos);
      check($sformatf("%s_term%0d_dummy", tag, i), obs_q[i].dummy, exp_q[i].dummy);
    end
    if (poke_start) bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    check({tag, "_idle_busy"}, bus.busy_o, 0);
    check({tag, "_idle_done"}, bus.done_o, 0);
  endtask

  initial begin
    int  cyc, issues;
    bit  prev_valid, seen_done;
    rst = 1'b1;
    bus.start_i = 1'b0; bus.weight_i = '0; bus.dummy_i = '0; bus.rnd_i = 1'b0;
    bus.dpos_i = '0; bus.op_ready_i = 1'b0;
    randomize_data();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Real terms only.
    ram[0] = 16'h0010; ram[1] = 16'h0123; ram[2] = 16'h0456; ram[3] = 16'h1FFF;
    run_job("real_only", 4, 0, 0, 0, 1'b0);
    check("real_only_18", lat, 18);

    // Interleave with fixed decisions; the fourth slot is forced real.
    rnd_seq[0] = 1'b1; rnd_seq[1] = 1'b0; rnd_seq[2] = 1'b1; rnd_seq[3] = 1'b1;
    for (int i = 0; i < 8; i++) dpos_seq[i] = 16'h00AA;
    run_job("interleave", 2, 2, 0, 0, 1'b0);

    // Backpressure on the first term.
    randomize_data();
    run_job("backpressure", 1, 1, 0, 5, 1'b0);
    check("backpressure_15", lat, 15);

    // Zero job, then start during a running job and in the DONE cycle.
    run_job("zero_job", 0, 0, 0, 0, 1'b0);
    check("zero_job_2", lat, 2);
    randomize_data();
    run_job("ignored_start", 2, 1, 0, 0, 1'b1);

    // Reset during the second ISSUE.
    randomize_data();
    @(negedge clk);
    bus.start_i = 1'b1; bus.weight_i = LW'(3); bus.dummy_i = LW'(2);
    bus.rnd_i = rnd_seq[0]; bus.dpos_i = dpos_seq[0]; bus.op_ready_i = 1'b1;
    cyc = 1; issues = 0; prev_valid = 1'b0; seen_done = 1'b0;
    while (issues < 2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      bus.start_i = 1'b0;
      if (bus.done_o) seen_done = 1'b1;
      if (bus.op_valid_o && !prev_valid) issues++;
      prev_valid = bus.op_valid_o;
    end
    check("midrst_reached_issue", issues, 2);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    check("midrst_no_done", seen_done, 0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_done_after", bus.done_o, 0);
    randomize_data();
    run_job("after_rst", 3, 2, 0, 0, 1'b0);

    // Randomized jobs with random backpressure.
    for (int j = 0; j < 10; j++) begin
      randomize_data();
      run_job($sformatf("rand%0d", j), $urandom_range(8), $urandom_range(8), 30, 0, 1'b0);
    end
    randomize_data();
    run_job("rand_big", 40, 25, 20, 3, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
